// File: rtl/alu_multicycle.sv
// alu_multicycle: integer ALU for the RISC-V datapath with a registered result and a
// start/busy/done handshake. Logic, add/sub, shift and compare ops finish in a single cycle.
// MUL/MULHU use an iterative shift-add unit. DIV/DIVU/REM/REMU use an iterative restoring
// divider. Both iterative units take `width` cycles.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request, sampled only while idle
//   operation  4-bit operation select, sampled with start
//   data1      operand A, sampled with start
//   data2      operand B, sampled with start
//   busy       high while an iterative operation is in flight
//   done       one-cycle pulse when aluResult has been updated
//   aluResult  registered result, held until the next done
//   zero       high when aluResult is zero
module alu_multicycle #(
  parameter int unsigned width = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [width-1:0] data1,
  input  logic [width-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] aluResult,
  output logic             zero
);

  localparam int unsigned shw = $clog2(width);
  localparam int unsigned cw  = $clog2(width + 1);

  localparam logic [cw-1:0] cnt_init = cw'(width);
  localparam logic [cw-1:0] cnt_last = cw'(1);

  localparam logic [width-1:0] min_neg = {1'b1, {(width - 1){1'b0}}};

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_mul  = 2'd1;
  localparam logic [1:0] st_div  = 2'd2;

  localparam logic [3:0] op_and   = 4'b0000;
  localparam logic [3:0] op_or    = 4'b0001;
  localparam logic [3:0] op_add   = 4'b0010;
  localparam logic [3:0] op_xor   = 4'b0011;
  localparam logic [3:0] op_sll   = 4'b0100;
  localparam logic [3:0] op_srl   = 4'b0101;
  localparam logic [3:0] op_sub   = 4'b0110;
  localparam logic [3:0] op_slt   = 4'b0111;
  localparam logic [3:0] op_sltu  = 4'b1000;
  localparam logic [3:0] op_sra   = 4'b1001;
  localparam logic [3:0] op_mul   = 4'b1010;
  localparam logic [3:0] op_mulhu = 4'b1011;
  localparam logic [3:0] op_divu  = 4'b1100;
  localparam logic [3:0] op_remu  = 4'b1101;
  localparam logic [3:0] op_div   = 4'b1110;
  localparam logic [3:0] op_rem   = 4'b1111;

  // State registers
  logic [1:0]         state_q, state_d;
  logic [cw-1:0]      cnt_q, cnt_d;
  logic [2*width-1:0] acc_q, acc_d;      // product accumulator; low half starts as multiplier
  logic [width-1:0]   mcand_q, mcand_d;
  logic [width-1:0]   rem_q, rem_d;      // partial remainder
  logic [width-1:0]   quo_q, quo_d;      // dividend shifts out, quotient shifts in
  logic [width-1:0]   dvsr_q, dvsr_d;
  logic               hi_q, hi_d;        // MULHU: keep the upper half
  logic               remsel_q, remsel_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [width-1:0]   result_q, result_d;
  logic               done_q, done_d;

  // Operation decode
  logic [shw-1:0] shamt;
  logic           is_mul;
  logic           is_div;
  logic           is_sdiv;
  logic           is_rem;
  logic           div_ovf;
  logic           neg1;
  logic           neg2;
  logic [width-1:0] mag1;
  logic [width-1:0] mag2;

  assign shamt   = data2[shw-1:0];
  assign is_mul  = (operation == op_mul) || (operation == op_mulhu);
  assign is_div  = (operation == op_divu) || (operation == op_remu) ||
                   (operation == op_div)  || (operation == op_rem);
  assign is_sdiv = (operation == op_div) || (operation == op_rem);
  assign is_rem  = (operation == op_remu) || (operation == op_rem);
  assign div_ovf = is_sdiv && (data1 == min_neg) && (data2 == {width{1'b1}});
  assign neg1    = is_sdiv & data1[width-1];
  assign neg2    = is_sdiv & data2[width-1];
  // Negating the most negative value yields its correct unsigned magnitude.
  assign mag1    = neg1 ? -data1 : data1;
  assign mag2    = neg2 ? -data2 : data2;

  // Single-cycle datapath
  logic [width-1:0] alu_out;

  always_comb begin
    alu_out = '0;
    case (operation)
      op_and:  alu_out = data1 & data2;
      op_or:   alu_out = data1 | data2;
      op_xor:  alu_out = data1 ^ data2;
      op_add:  alu_out = data1 + data2;
      op_sub:  alu_out = data1 - data2;
      op_sll:  alu_out = data1 << shamt;
      op_srl:  alu_out = data1 >> shamt;
      op_sra:  alu_out = $unsigned($signed(data1) >>> shamt);
      op_slt:  alu_out = {{(width - 1){1'b0}}, ($signed(data1) < $signed(data2))};
      op_sltu: alu_out = {{(width - 1){1'b0}}, (data1 < data2)};
      default: alu_out = '0;
    endcase
  end

  // One shift-add step: add the multiplicand to the upper half when the current multiplier
  // bit is set, then shift the whole accumulator right with the carry.
  logic [width:0]     mul_sum;
  logic [2*width-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*width-1:width]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign mul_next = {mul_sum, acc_q[width-1:1]};

  // One restoring-division step. The partial remainder stays below the divisor, so the
  // difference fits in width bits whenever the subtraction is kept.
  logic [width:0]   div_shift;
  logic             div_ge;
  logic [width-1:0] div_diff;
  logic [width-1:0] rem_next;
  logic [width-1:0] quo_next;

  assign div_shift = {rem_q, quo_q[width-1]};
  assign div_ge    = div_shift >= {1'b0, dvsr_q};
  assign div_diff  = div_shift[width-1:0] - dvsr_q;
  assign rem_next  = div_ge ? div_diff : div_shift[width-1:0];
  assign quo_next  = {quo_q[width-2:0], div_ge};

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    hi_d     = hi_q;
    remsel_d = remsel_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      st_idle: begin
        if (start) begin
          if (is_mul) begin
            acc_d   = {{width{1'b0}}, data2};
            mcand_d = data1;
            hi_d    = (operation == op_mulhu);
            cnt_d   = cnt_init;
            state_d = st_mul;
          end else if (is_div) begin
            if (data2 == '0) begin
              result_d = is_rem ? data1 : {width{1'b1}};
              done_d   = 1'b1;
            end else if (div_ovf) begin
              result_d = is_rem ? '0 : data1;
              done_d   = 1'b1;
            end else begin
              rem_d    = '0;
              quo_d    = mag1;
              dvsr_d   = mag2;
              remsel_d = is_rem;
              qneg_d   = neg1 ^ neg2;
              rneg_d   = neg1;
              cnt_d    = cnt_init;
              state_d  = st_div;
            end
          end else begin
            result_d = alu_out;
            done_d   = 1'b1;
          end
        end
      end

      st_mul: begin
        acc_d = mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == cnt_last) begin
          result_d = hi_q ? mul_next[2*width-1:width] : mul_next[width-1:0];
          done_d   = 1'b1;
          state_d  = st_idle;
        end
      end

      st_div: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == cnt_last) begin
          // Sign fix is folded into the final iteration.
          if (remsel_q) begin
            result_d = rneg_q ? -rem_next : rem_next;
          end else begin
            result_d = qneg_q ? -quo_next : quo_next;
          end
          done_d  = 1'b1;
          state_d = st_idle;
        end
      end

      default: begin
        state_d = st_idle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= st_idle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      hi_q     <= 1'b0;
      remsel_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      hi_q     <= hi_d;
      remsel_q <= remsel_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != st_idle);
  assign done      = done_q;
  assign aluResult = result_q;
  assign zero      = (result_q == '0);

endmodule
